// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - load/store request bus between the memory execute stage and the data RAM responder
interface dmem_if;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [1:0]  byte_size;
  logic [31:0] mem_data_out;
  logic        mem_read_ready;
  logic        mem_write_ready;
  logic        access_err;
  logic        busy;

  modport master (
    output mem_read_en, mem_write_en, mem_addr, mem_data, byte_size,
    input  mem_data_out, mem_read_ready, mem_write_ready, access_err, busy
  );

  modport slave (
    input  mem_read_en, mem_write_en, mem_addr, mem_data, byte_size,
    output mem_data_out, mem_read_ready, mem_write_ready, access_err, busy
  );
endinterface

// File: rtl/dmem_resp.sv
// rtl/dmem_resp.sv - data-memory responder with wait states, byte-lane steering and fault detection
module dmem_resp #(
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 0
) (
  input logic   clk,
  input logic   rst,
  dmem_if.slave bus
);
  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] SPAN      = 32'(4 * DEPTH);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
  localparam bit          NO_WAIT   = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_GAP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        cap_rd, cap_wr;
  logic [31:0] cap_addr, cap_data;
  logic [1:0]  cap_size;

  logic [31:0] ram [DEPTH];

  logic          take, resp_go, fault, ram_we;
  logic          req_rd, req_wr;
  logic [31:0]   req_addr, req_data, off;
  logic [1:0]    req_size, lane;
  logic [AW-1:0] word_idx;
  logic [31:0]   rd_word, shifted, load_data, st_data;
  logic [3:0]    st_lanes;

  // Decode the request being answered: live inputs in IDLE (zero-wait path), captured copy afterwards
  always_comb begin
    take = (state == S_IDLE) && (bus.mem_read_en || bus.mem_write_en);
    if (state == S_IDLE) begin
      req_rd   = bus.mem_read_en;
      req_wr   = bus.mem_write_en;
      req_addr = bus.mem_addr;
      req_data = bus.mem_data;
      req_size = bus.byte_size;
    end else begin
      req_rd   = cap_rd;
      req_wr   = cap_wr;
      req_addr = cap_addr;
      req_data = cap_data;
      req_size = cap_size;
    end
    resp_go  = (take && NO_WAIT) || (state == S_WAIT && cnt == 4'd1);
    off      = req_addr - BASE_ADDR;
    word_idx = off[AW+1:2];
    lane     = off[1:0];
    fault    = (req_rd && req_wr)
            || (req_addr < BASE_ADDR) || (off >= SPAN)
            || (req_size == 2'd3)
            || (req_size == 2'd2 && lane[0])
            || (req_size == 2'd0 && lane != 2'd0);
    rd_word  = ram[word_idx];
    shifted  = rd_word >> {lane, 3'b000};
    case (req_size)
      2'd1:    load_data = shifted & 32'h0000_00FF;
      2'd2:    load_data = shifted & 32'h0000_FFFF;
      default: load_data = rd_word;
    endcase
    case (req_size)
      2'd1: begin
        st_lanes = 4'b0001 << lane;
        st_data  = req_data << {lane, 3'b000};
      end
      2'd2: begin
        st_lanes = 4'b0011 << lane;
        st_data  = req_data << {lane, 3'b000};
      end
      default: begin
        st_lanes = 4'b1111;
        st_data  = req_data;
      end
    endcase
    // A request seen while reset is held must never reach the array
    ram_we = resp_go && req_wr && !fault && !rst;
  end

  // RAM array: per-lane writes, contents survive reset
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (st_lanes[i]) ram[word_idx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

  // Request FSM with registered response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= S_IDLE;
      cnt                 <= 4'd0;
      cap_rd              <= 1'b0;
      cap_wr              <= 1'b0;
      cap_addr            <= 32'd0;
      cap_data            <= 32'd0;
      cap_size            <= 2'd0;
      bus.mem_data_out    <= 32'd0;
      bus.mem_read_ready  <= 1'b0;
      bus.mem_write_ready <= 1'b0;
      bus.access_err      <= 1'b0;
      bus.busy            <= 1'b0;
    end else begin
      bus.mem_read_ready  <= 1'b0;
      bus.mem_write_ready <= 1'b0;
      bus.access_err      <= 1'b0;
      case (state)
        S_IDLE: begin
          bus.busy <= take;
          if (take) begin
            cap_rd   <= bus.mem_read_en;
            cap_wr   <= bus.mem_write_en;
            cap_addr <= bus.mem_addr;
            cap_data <= bus.mem_data;
            cap_size <= bus.byte_size;
            if (NO_WAIT) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              cnt   <= WAIT_INIT;
            end
          end
        end
        S_WAIT: begin
          bus.busy <= 1'b1;
          cnt      <= cnt - 4'd1;
          if (cnt == 4'd1) state <= S_RESP;
        end
        S_RESP: begin
          bus.busy <= 1'b1;
          state    <= S_GAP;
        end
        S_GAP: begin
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
      if (resp_go) begin
        bus.mem_read_ready  <= req_rd;
        bus.mem_write_ready <= req_wr;
        bus.access_err      <= fault;
        if (req_rd) bus.mem_data_out <= fault ? 32'd0 : load_data;
      end
    end
  end
endmodule
